// File: rtl/hw_enc_pkg.sv
// Shared types and sizing for the 8:3 encoder queue.
package hw_enc_pkg;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  typedef enum logic {EMPTY, FULL} enc_state_t;

  typedef logic [N-1:0] req_vec_t;

endpackage

// File: rtl/hw_8_3_prio_enc.sv
// Combinational priority encoder: highest set request index wins.
module hw_8_3_prio_enc #(
  parameter int unsigned N = hw_enc_pkg::N,
  parameter int unsigned W = hw_enc_pkg::W
) (
  input  logic [N-1:0] req,
  output logic         any,
  output logic [W-1:0] sel
);

  // Ascending scan so the last (highest) set bit overrides lower ones.
  always_comb begin
    any = 1'b0;
    sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i]) begin
        any = 1'b1;
        sel = W'(i);
      end
    end
  end

endmodule

// File: rtl/hw_8_3_encoder_queue.sv
// Registered 8:3 priority encoder: per-line request capture into a pending
// register, issued one index at a time over a valid/ready handshake.
module hw_8_3_encoder_queue #(
  parameter int unsigned N = hw_enc_pkg::N,
  parameter int unsigned W = hw_enc_pkg::W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         EN,
  input  logic [N-1:0] d,
  output logic [W-1:0] q,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pending,
  output logic         ovf
);

  import hw_enc_pkg::*;

  enc_state_t   state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] clr_mask;
  logic [W-1:0] q_q, q_d;
  logic         valid_q, valid_d;
  logic         ovf_q, ovf_d;
  logic         any;
  logic [W-1:0] sel;
  logic         load;

  hw_8_3_prio_enc #(
    .N (N),
    .W (W)
  ) u_prio_enc (
    .req (pending_q),
    .any (any),
    .sel (sel)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    valid_d = valid_q;
    load    = 1'b0;

    case (state_q)
      EMPTY: begin
        if (any) begin
          load    = 1'b1;
          q_d     = sel;
          valid_d = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (ready) begin
          if (any) begin
            load = 1'b1;
            q_d  = sel;
          end else begin
            valid_d = 1'b0;
            state_d = EMPTY;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = EMPTY;
      end
    endcase

    clr_mask = '0;
    if (load) begin
      clr_mask[sel] = 1'b1;
    end

    // Capture is applied after the load-clear so a same-edge request for the
    // index being issued survives as a fresh event rather than an overflow.
    pending_d = pending_q & ~clr_mask;
    ovf_d     = 1'b0;
    if (EN) begin
      pending_d = pending_d | d;
      ovf_d     = |(d & pending_q & ~clr_mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      pending_q <= '0;
      q_q       <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      q_q       <= q_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign q       = q_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_hw_8_3_encoder_queue.sv
// Directed bench for hw_8_3_encoder_queue with an issue-order scoreboard.
module tb_hw_8_3_encoder_queue;

  logic       clk;
  logic       rst_n;
  logic       EN;
  logic [7:0] d;
  logic [2:0] q;
  logic       valid;
  logic       ready;
  logic [7:0] pending;
  logic       ovf;

  int unsigned n_assert;
  int unsigned n_fail;
  logic [2:0]  sb[$];

  hw_8_3_encoder_queue #(
    .N (8),
    .W (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .EN      (EN),
    .d       (d),
    .q       (q),
    .valid   (valid),
    .ready   (ready),
    .pending (pending),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_issue(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_q"}, 32'(q), 32'(sb.pop_front()));
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    EN    = 1'b0;
    d     = '0;
    ready = 1'b0;
    tick();
    tick();
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single event
    EN = 1'b1; ready = 1'b1; d = 8'b0000_0100; sb.push_back(3'd2);
    tick();
    d = '0;
    chk("single_pend", 32'(pending), 32'h04);
    chk("single_novalid", 32'(valid), 32'd0);
    tick();
    expect_issue("single");
    chk("single_pend_clr", 32'(pending), 32'h00);
    tick();
    chk("single_drain", 32'(valid), 32'd0);

    // Priority order
    d = 8'b1001_0010;
    sb.push_back(3'd7); sb.push_back(3'd4); sb.push_back(3'd1);
    tick();
    d = '0;
    chk("prio_pend", 32'(pending), 32'h92);
    tick();
    expect_issue("prio7");
    chk("prio_pend1", 32'(pending), 32'h12);
    tick();
    expect_issue("prio4");
    tick();
    expect_issue("prio1");
    chk("prio_pend0", 32'(pending), 32'h00);
    tick();
    chk("prio_drain", 32'(valid), 32'd0);

    // Back-pressure
    ready = 1'b0; d = 8'b0000_1001;
    sb.push_back(3'd3); sb.push_back(3'd0);
    tick();
    d = '0;
    tick();
    expect_issue("bp3");
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_q", 32'(q), 32'd3);
      chk("bp_hold_valid", 32'(valid), 32'd1);
      chk("bp_hold_pend", 32'(pending), 32'h01);
    end
    ready = 1'b1;
    tick();
    expect_issue("bp0");
    chk("bp_pend0", 32'(pending), 32'h00);
    tick();
    chk("bp_drain", 32'(valid), 32'd0);

    // Overflow and re-request
    ready = 1'b0; d = 8'b0010_0000; sb.push_back(3'd5);
    tick();
    d = '0;
    tick();
    expect_issue("ovf_first");
    chk("ovf_pend_empty", 32'(pending), 32'h00);
    tick();
    d = 8'b0010_0000;
    tick();
    d = '0;
    chk("rereq_pend", 32'(pending), 32'h20);
    chk("rereq_no_ovf", 32'(ovf), 32'd0);
    tick();
    chk("rereq_hold_q", 32'(q), 32'd5);
    d = 8'b0010_0000;
    tick();
    d = '0;
    chk("ovf_pulse", 32'(ovf), 32'd1);
    chk("ovf_pend", 32'(pending), 32'h20);
    tick();
    chk("ovf_one_cycle", 32'(ovf), 32'd0);
    chk("ovf_pend_keep", 32'(pending), 32'h20);
    ready = 1'b1; sb.push_back(3'd5);
    tick();
    expect_issue("ovf_second");
    chk("ovf_pend_clr", 32'(pending), 32'h00);
    tick();
    chk("ovf_drain", 32'(valid), 32'd0);

    // Capture of the index being loaded on the same edge
    d = 8'b0000_0100; sb.push_back(3'd2);
    tick();
    sb.push_back(3'd2);
    tick();
    d = '0;
    expect_issue("same_first");
    chk("same_pend", 32'(pending), 32'h04);
    chk("same_no_ovf", 32'(ovf), 32'd0);
    tick();
    expect_issue("same_second");
    chk("same_pend_clr", 32'(pending), 32'h00);
    tick();
    chk("same_drain", 32'(valid), 32'd0);

    // EN gating
    EN = 1'b0; d = 8'hFF;
    tick();
    tick();
    tick();
    chk("en_pend", 32'(pending), 32'h00);
    chk("en_valid", 32'(valid), 32'd0);
    chk("en_ovf", 32'(ovf), 32'd0);
    d = '0; EN = 1'b1;

    // Reset mid-operation
    ready = 1'b0; d = 8'hF0; sb.push_back(3'd7);
    tick();
    d = '0;
    tick();
    d = 8'h80;
    tick();
    d = '0;
    expect_issue("mid_q7");
    chk("mid_pend", 32'(pending), 32'hF0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q", 32'(q), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_pending", 32'(pending), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
